// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial unsigned subtractor computing Diff = A - B with a borrow out.
//   One difference bit is produced per clock, LSB first, by a single
//   subtractor cell whose borrow is kept in a flop between bits. Operands
//   are captured on the edge that accepts start; the result registers
//   update only on the last RUN edge and hold between operations.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      synchronous active-low reset, aborts any operation
//   start  in   1      request, sampled when the unit can take new work
//   A      in   WIDTH  minuend, captured with start
//   B      in   WIDTH  subtrahend, captured with start
//   busy   out  1      high while an operation runs or completes
//   done   out  1      one-cycle pulse, Diff/Bout valid
//   Diff   out  WIDTH  (A - B) mod 2^WIDTH
//   Bout   out  1      1 iff A < B
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Full-subtractor cell: returns {borrow_out, diff_bit}.
  function automatic logic [1:0] sub_cell(input logic a, input logic b,
                                          input logic br);
    logic d;
    logic bo;
    d  = a ^ b ^ br;
    bo = (~a & b) | (~(a ^ b) & br);
    return {bo, d};
  endfunction

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic [1:0]       w_cell;
  logic             w_d;
  logic             w_borrow_nxt;
  logic [WIDTH:0]   w_work_ext;
  logic [WIDTH-1:0] w_work_nxt;

  assign w_cell       = sub_cell(r_a[0], r_b[0], r_borrow);
  assign w_d          = w_cell[0];
  assign w_borrow_nxt = w_cell[1];

  // New bit enters at the MSB; written via a WIDTH+1 vector so WIDTH=1 works.
  assign w_work_ext = {w_d, r_work};
  assign w_work_nxt = w_work_ext[WIDTH:1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_work   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= A;
            r_b      <= B;
            r_work   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_work   <= w_work_nxt;
          r_borrow <= w_borrow_nxt;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_diff  <= w_work_nxt;
            r_bout  <= w_borrow_nxt;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // The edge leaving DONE doubles as an accept slot, so start held
          // high yields one operation every WIDTH+1 cycles.
          if (start) begin
            r_a      <= A;
            r_b      <= B;
            r_work   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_state  <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign Diff = r_diff;
  assign Bout = r_bout;

endmodule
